// File: rtl/filterbank_scheduler.sv
// rtl/filterbank_scheduler.sv - time-multiplexes one band-filter engine across NUM_CH vocoder bands
module filterbank_scheduler #(
    parameter int NUM_CH       = 8,
    parameter int SAMPLE_WIDTH = 24,
    parameter int RESULT_WIDTH = 32,
    parameter int TIMEOUT      = 255
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           valid_in,
    input  logic signed [SAMPLE_WIDTH-1:0] carrier_in,
    input  logic signed [SAMPLE_WIDTH-1:0] modulator_in,
    output logic                           eng_start_out,
    output logic [$clog2(NUM_CH)-1:0]      eng_ch_out,
    output logic                           eng_src_out,
    output logic signed [SAMPLE_WIDTH-1:0] eng_sample_out,
    input  logic                           eng_done_in,
    input  logic signed [RESULT_WIDTH-1:0] eng_result_in,
    output logic signed [RESULT_WIDTH-1:0] carrier_out [NUM_CH],
    output logic signed [RESULT_WIDTH-1:0] modulator_out [NUM_CH],
    output logic                           valid_out,
    output logic                           busy_out,
    output logic [7:0]                     overrun_cnt_out,
    output logic                           timeout_out
);
    localparam int CW = $clog2(NUM_CH);
    localparam int JW = CW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [JW-1:0] LAST_JOB = JW'(2 * NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PUBLISH
    } state_t;

    state_t state_q, state_d;
    logic [JW-1:0] job_q, next_job;
    logic [WW-1:0] wait_q;
    logic signed [SAMPLE_WIDTH-1:0] car_lat, mod_lat;
    logic signed [RESULT_WIDTH-1:0] shadow_car [NUM_CH];
    logic signed [RESULT_WIDTH-1:0] shadow_mod [NUM_CH];
    logic signed [RESULT_WIDTH-1:0] store_val;
    logic advance, expired;

    // done beats a coincident expiry: the result is kept and no timeout is flagged
    always_comb begin
        state_d   = state_q;
        advance   = 1'b0;
        expired   = 1'b0;
        next_job  = job_q + 1'b1;
        store_val = eng_done_in ? eng_result_in : '0;
        case (state_q)
            S_IDLE:    if (valid_in) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT: begin
                if (eng_done_in) begin
                    advance = 1'b1;
                end else if (wait_q == WW'(TIMEOUT - 1)) begin
                    advance = 1'b1;
                    expired = 1'b1;
                end
                if (advance) state_d = (job_q == LAST_JOB) ? S_PUBLISH : S_ISSUE;
            end
            S_PUBLISH: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign eng_start_out = (state_q == S_ISSUE);
    assign valid_out     = (state_q == S_PUBLISH);
    assign busy_out      = (state_q != S_IDLE);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q         <= S_IDLE;
            job_q           <= '0;
            wait_q          <= '0;
            car_lat         <= '0;
            mod_lat         <= '0;
            eng_ch_out      <= '0;
            eng_src_out     <= 1'b0;
            eng_sample_out  <= '0;
            overrun_cnt_out <= '0;
            timeout_out     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && valid_in) begin
                car_lat        <= carrier_in;
                mod_lat        <= modulator_in;
                job_q          <= '0;
                eng_ch_out     <= '0;
                eng_src_out    <= 1'b0;
                eng_sample_out <= carrier_in;
            end
            if (state_q != S_IDLE && valid_in && overrun_cnt_out != 8'hFF)
                overrun_cnt_out <= overrun_cnt_out + 8'd1;
            if (state_q == S_ISSUE)
                wait_q <= '0;
            else if (state_q == S_WAIT && wait_q != WW'(TIMEOUT))
                wait_q <= wait_q + 1'b1;
            if (expired)
                timeout_out <= 1'b1;
            // job k maps to band k>>1, pass k&1; engine-facing fields are set on entry to ISSUE
            if (advance && job_q != LAST_JOB) begin
                job_q          <= next_job;
                eng_ch_out     <= next_job[JW-1:1];
                eng_src_out    <= next_job[0];
                eng_sample_out <= next_job[0] ? mod_lat : car_lat;
            end
        end
    end

    // the final job's result bypasses the shadow so it lands in the published bank on the same edge
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_car[i]    <= '0;
                shadow_mod[i]    <= '0;
                carrier_out[i]   <= '0;
                modulator_out[i] <= '0;
            end
        end else if (advance) begin
            if (eng_src_out)
                shadow_mod[eng_ch_out] <= store_val;
            else
                shadow_car[eng_ch_out] <= store_val;
            if (job_q == LAST_JOB) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    carrier_out[i]   <= shadow_car[i];
                    modulator_out[i] <= (i == NUM_CH - 1) ? store_val : shadow_mod[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_filterbank_scheduler.sv
// tb/tb_filterbank_scheduler.sv - scoreboard bench for filterbank_scheduler
module tb_filterbank_scheduler;
    localparam int NC = 8;
    localparam int TO = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, valid_in;
    logic signed [23:0] carrier_in, modulator_in;
    logic eng_start, eng_src, eng_done;
    logic [2:0] eng_ch;
    logic signed [23:0] eng_sample;
    logic signed [31:0] eng_result;
    logic signed [31:0] car_o [NC];
    logic signed [31:0] mod_o [NC];
    logic valid_out, busy, to_o;
    logic [7:0] ovr;

    filterbank_scheduler #(.NUM_CH(NC), .SAMPLE_WIDTH(24), .RESULT_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in),
        .carrier_in(carrier_in), .modulator_in(modulator_in),
        .eng_start_out(eng_start), .eng_ch_out(eng_ch), .eng_src_out(eng_src),
        .eng_sample_out(eng_sample), .eng_done_in(eng_done), .eng_result_in(eng_result),
        .carrier_out(car_o), .modulator_out(mod_o), .valid_out(valid_out),
        .busy_out(busy), .overrun_cnt_out(ovr), .timeout_out(to_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0, nfail = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0]      cyc;
        logic [NC*32-1:0] cb;
        logic [NC*32-1:0] mb;
        logic             to;
    } pub_t;
    logic [27:0] startq[$];
    pub_t pubq[$];

    // engine model: done L cycles after start, result {ch,src,sample[7:0]}; lat=0 never answers
    int lat = 3, spur_at = -1, n_starts = 0, ml;
    logic done_m = 1'b0, spur_a = 1'b0, spur_b = 1'b0;
    logic [31:0] res_m = '0, mr;
    assign eng_done   = done_m | spur_a | spur_b;
    assign eng_result = spur_a ? 32'hA5A5A5A5 : spur_b ? 32'h5A5A5A5A : res_m;

    always begin
        @(negedge clk);
        if (eng_start === 1'b1) begin
            ml = lat;
            mr = {20'd0, eng_ch, eng_src, eng_sample[7:0]};
            if (n_starts == spur_at && ml > 1) begin
                spur_b = 1'b1;
                @(posedge clk);
                #1 spur_b = 1'b0;
                ml = ml - 1;
                if (ml > 0) begin
                    repeat (ml) @(posedge clk);
                    #1 done_m = 1'b1; res_m = mr;
                    @(posedge clk);
                    #1 done_m = 1'b0;
                end
            end else if (ml > 0) begin
                repeat (ml) @(posedge clk);
                #1 done_m = 1'b1; res_m = mr;
                @(posedge clk);
                #1 done_m = 1'b0;
            end
            n_starts++;
        end
    end

    // monitor: pops expected starts and publications as the DUT presents them
    pub_t p;
    logic [27:0] se;
    always @(negedge clk) begin
        if (eng_start === 1'b1) begin
            if (startq.size() == 0) chk("spurious_start", eng_start, 0);
            else begin
                se = startq.pop_front();
                chk("start_job", {eng_ch, eng_src, eng_sample}, se);
            end
        end
        if (valid_out === 1'b1) begin
            if (pubq.size() == 0) chk("spurious_valid", valid_out, 0);
            else begin
                p = pubq.pop_front();
                chk("valid_cycle", cyc, p.cyc);
                chk("timeout_flag", to_o, p.to);
                for (int i = 0; i < NC; i++) begin
                    chk($sformatf("carrier_out[%0d]", i), car_o[i], p.cb[i*32 +: 32]);
                    chk($sformatf("modulator_out[%0d]", i), mod_o[i], p.mb[i*32 +: 32]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [23:0] c, input logic [23:0] m);
        valid_in = 1'b1; carrier_in = c; modulator_in = m;
        tick(1);
        valid_in = 1'b0;
    endtask

    task automatic send(input logic [23:0] c, input logic [23:0] m, input int l, input logic to_exp);
        pub_t e;
        int eff;
        eff = (l == 0) ? TO : l;
        e.cyc = 32'(cyc + 16 * (eff + 1) + 1);
        e.to = to_exp;
        e.cb = '0;
        e.mb = '0;
        for (int k = 0; k < 2 * NC; k++) begin
            logic [2:0] ch;
            ch = 3'(k >> 1);
            startq.push_back({ch, k[0], (k[0] ? m : c)});
        end
        if (l != 0)
            for (int i = 0; i < NC; i++) begin
                e.cb[i*32 +: 32] = {20'd0, 3'(i), 1'b0, c[7:0]};
                e.mb[i*32 +: 32] = {20'd0, 3'(i), 1'b1, m[7:0]};
            end
        pubq.push_back(e);
        pulse(c, m);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000; i++) begin
            if (busy === 1'b0 && pubq.size() == 0 && startq.size() == 0) break;
            tick(1);
        end
        chk("sequence_complete", {busy, 8'(pubq.size())}, 9'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, valid_out, 0);
        chk({tag, "_start"}, eng_start, 0);
        chk({tag, "_eng"}, {eng_ch, eng_src, eng_sample}, 0);
        chk({tag, "_overrun"}, ovr, 0);
        chk({tag, "_timeout"}, to_o, 0);
        for (int i = 0; i < NC; i++) begin
            chk($sformatf("%s_car[%0d]", tag, i), car_o[i], 0);
            chk($sformatf("%s_mod[%0d]", tag, i), mod_o[i], 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; carrier_in = '0; modulator_in = '0;
        tick(2);
        chk_zero("reset");
        rst_n = 1'b1;
        tick(2);

        spur_a = 1'b1;
        tick(1);
        spur_a = 1'b0;
        tick(3);
        chk("idle_spur_busy", busy, 0);
        chk("idle_spur_car0", car_o[0], 0);
        chk("idle_spur_mod0", mod_o[0], 0);

        lat = 3; spur_at = n_starts;
        send(24'h123456, 24'hABCDEF, 3, 1'b0);
        wait_done();
        spur_at = -1;

        lat = TO;
        send(24'h000080, 24'hFFFF7F, TO, 1'b0);
        wait_done();

        lat = 3;
        send(24'h000011, 24'h000022, 3, 1'b0);
        tick(19);
        pulse(24'h0000E1, 24'h0000E2); tick(19);
        pulse(24'h0000E3, 24'h0000E4); tick(19);
        pulse(24'h0000E5, 24'h0000E6); tick(19);
        send(24'h000033, 24'h000044, 3, 1'b0);
        wait_done();
        chk("overrun_3", ovr, 3);

        lat = 0;
        send(24'h000055, 24'h000066, 0, 1'b1);
        valid_in = 1'b1; carrier_in = 24'h0000F0; modulator_in = 24'h0000F1;
        tick(170);
        valid_in = 1'b0;
        wait_done();
        chk("overrun_173", ovr, 173);
        send(24'h000077, 24'h000088, 0, 1'b1);
        valid_in = 1'b1;
        tick(150);
        valid_in = 1'b0;
        wait_done();
        chk("overrun_sat", ovr, 255);

        lat = 3;
        send(24'h000099, 24'h0000AA, 3, 1'b1);
        wait_done();

        send(24'h0000BB, 24'h0000CC, 3, 1'b1);
        tick(21);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        chk("midreset_jobs_left", startq.size(), 10);
        startq.delete();
        pubq.delete();
        tick(2);
        rst_n = 1'b1;
        tick(10);
        chk("post_reset_idle", busy, 0);
        send(24'h0000DD, 24'h0000EE, 3, 1'b0);
        wait_done();
        chk("post_reset_overrun", ovr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected completion before time limit");
        $fatal(1);
    end
endmodule
